// File: rtl/led_sequencer.sv
// LED pattern generator: four step patterns at STEP_DIV cycles/step, PWM brightness, registered LPORT.
// Latency: LPORT follows pat and brightness by one edge; no backpressure, en only freezes stepping.
module led_sequencer #(
   parameter int STEP_DIV = 1200000,
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [7:0]          LPORT,
   output logic                step
);

   localparam int PW = $clog2(STEP_DIV);

   typedef enum logic {LEFT, RIGHT} dir_t;

   logic [7:0]          pat, pat_n;
   logic [PW-1:0]       presc, presc_n;
   dir_t                dir, dir_n;
   logic [1:0]          mode_q, mode_n;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                step_n;
   logic                tick;
   logic                pwm_on;
   logic [7:0]          lport_n;

   function automatic logic [7:0] init_pat(input logic [1:0] m);
      case (m)
         2'd0:    return 8'hAA;
         2'd1:    return 8'h01;
         2'd2:    return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

   assign tick    = en && (presc == PW'(STEP_DIV - 1));
   assign pwm_on  = (&brightness) || (pwm_cnt < brightness);
   assign lport_n = pwm_on ? pat : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= mode;
         pat     <= init_pat(mode);
         presc   <= '0;
         dir     <= LEFT;
         pwm_cnt <= '0;
         LPORT   <= 8'h00;
         step    <= 1'b0;
      end else begin
         mode_q  <= mode_n;
         pat     <= pat_n;
         presc   <= presc_n;
         dir     <= dir_n;
         pwm_cnt <= pwm_cnt + 1'b1;
         LPORT   <= lport_n;
         step    <= step_n;
      end
   end

   always_comb begin
      mode_n  = mode_q;
      pat_n   = pat;
      presc_n = presc;
      dir_n   = dir;
      step_n  = 1'b0;
      // A mode switch restarts the step period and wins over a coincident tick
      if (mode != mode_q) begin
         mode_n  = mode;
         pat_n   = init_pat(mode);
         presc_n = '0;
         dir_n   = LEFT;
      end else if (en) begin
         presc_n = tick ? '0 : presc + 1'b1;
         if (tick) begin
            step_n = 1'b1;
            case (mode_q)
               2'd0: pat_n = 8'hAA;
               2'd1: pat_n = {pat[6:0], pat[7]};
               2'd2: begin
                  if (dir == LEFT) begin
                     pat_n = {pat[6:0], 1'b0};
                     if (pat_n == 8'h80) dir_n = RIGHT;
                  end else begin
                     pat_n = {1'b0, pat[7:1]};
                     if (pat_n == 8'h01) dir_n = LEFT;
                  end
               end
               default: pat_n = pat + 8'd1;
            endcase
         end
      end
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Pattern generator that drives the 8 yellow LEDs on the IceZUM Alhambra and takes the place of a constant pattern on the LED port. It advances one of four selectable patterns at a fixed step rate derived from the board clock, and applies a global brightness via PWM before the registered `LPORT` output. It is the stage that produces the value the top level routes to the LED pins.

## Interface
- `STEP_DIV`, 1200000: clock cycles per pattern step (100 ms at 12 MHz); ≥ 2; prescaler width is clog2(`STEP_DIV`).
- `PWM_BITS`, 4: width of the brightness input and the PWM counter.

- `clk`  in  1: system clock (12 MHz on board).
- `rst`  in  1: synchronous reset, active-high.
- `en`  in  1: 1 = prescaler runs and pattern advances; 0 = freeze the pattern.
- `mode`  in  2: 0 static 0xAA; 1 rotate-left; 2 bounce (scanner); 3 binary up-count.
- `brightness`  in  `PWM_BITS`: 0 = dark; all-ones = fully on; other values give a duty of `brightness`/2^`PWM_BITS`.
- `LPORT`  out  8: registered LED drive, 1 = LED on.
- `step`  out  1: one-cycle pulse on every pattern step.

## Operation
- Internal state: `pat[7:0]`, `presc`, `dir` (LEFT/RIGHT), `mode_q[1:0]`, `pwm_cnt[PWM_BITS-1:0]`.
- Initial pattern per mode: mode 0 = 0xAA, mode 1 = 0x01, mode 2 = 0x01, mode 3 = 0x00.
- Reset: `mode_q` = `mode`, `pat` = the initial pattern for `mode`, `presc` = 0, `dir` = LEFT, `pwm_cnt` = 0, `LPORT` = 0x00, `step` = 0.
- Mode change: when `mode` ≠ `mode_q` at an edge:
  - `mode_q` = `mode`, `pat` = the initial pattern for the new mode, `presc` = 0, `dir` = LEFT.
  - `step` = 0 for that cycle.
  - This takes priority over a tick on the same edge.
- Prescaler:
  - When `en` = 1, `presc` increments every cycle.
  - When `presc` = `STEP_DIV`-1, the edge is a tick: `presc` wraps to 0.
  - When `en` = 0, `presc` holds.
- On a tick, the pattern advances according to `mode_q`:
  - mode 0: `pat` reloads 0xAA.
  - mode 1: `pat` rotates left by 1 (0x80 → 0x01).
  - mode 2, bounce FSM:
    - LEFT: `pat` shifts left 1; if the new `pat` = 0x80, `dir` goes to RIGHT.
    - RIGHT: `pat` shifts right 1; if the new `pat` = 0x01, `dir` goes to LEFT.
    - Sequence: 01, 02, …, 80, 40, …, 01, 02, …; period 14 steps.
  - mode 3: `pat` = `pat`+1 mod 256 (0xFF → 0x00).
- `step` = 1 for exactly the cycle after each tick edge, in every mode including mode 0.
- PWM:
  - `pwm_cnt` increments every cycle and wraps at 2^`PWM_BITS`. It is independent of `en` and `mode`.
  - `pwm_on` = (`brightness` all-ones) OR (`pwm_cnt` < `brightness`).
- Output register: `LPORT` <= `pwm_on` ? `pat` : 0x00, updated every cycle, using the `pat` value before the edge.

## Timing
- Edge 1 is the first rising edge with `rst` = 0, and `en` = 1 continuously from then.
- Ticks occur at edges `STEP_DIV`, 2·`STEP_DIV`, and so on.
- `pat` and `step` update on the tick edge. `LPORT` shows the new `pat` one edge later (latency 1).
- `brightness` is used combinationally into the `LPORT` register, so a change affects `LPORT` after 1 edge.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of `en`, `mode` or a pending tick.
- `en` deasserted on a tick edge: no tick; `presc` holds at `STEP_DIV`-1, and the tick occurs on the first edge with `en` = 1.

## Test plan
- STEP_DIV=4, mode=1, brightness=all-ones, en=1, from reset:
  - `step` pulses every 4 cycles.
  - `LPORT` = 0x01, 0x02, 0x04, …, 0x80, 0x01.
  - `LPORT` lags `step` by one cycle.
- Mode 2, 30 steps:
  - Sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02, …
  - 0x80 and 0x01 each appear exactly once per 14-step period.
- Mode 3:
  - 256 steps from 0x00 end back at 0x00.
  - Wrap 0xFF → 0x00 in a single step.
- Mode changed 1 → 3 on the same edge as a tick:
  - `pat` = 0x00 and no `step` pulse.
  - Next `step` arrives exactly `STEP_DIV` cycles later.
- `en`=0 for 10 cycles mid-step:
  - `pat` and `step` frozen; `LPORT` keeps following the PWM.
  - On re-enable the step period resumes where it left off.
- Mode 0, brightness=0 / 4 / all-ones, over 16 cycles:
  - `LPORT` = 0xAA for 0 / 4 / 16 cycles, 0x00 otherwise.
  - `rst` pulse → `LPORT` = 0x00 the next cycle.
